// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the sync-ROM address, and holds the IF/ID register.
// Redirects from EX win over stalls, and stalls win over ID jumps.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 14
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   jump,
  input  logic [25:0]            Jump_PC,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            Instruction,
  output logic [31:0]            opcplus4,
  output logic [31:0]            id_pc,
  output logic                   id_valid,
  output logic                   adderr
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_opcplus4;
  logic [31:0] r_id_pc;
  logic        r_id_valid;
  logic        r_adderr;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_jump_taken;
  logic        w_bubble;
  logic        w_misaligned;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_jump_taken = jump && r_id_valid && !stall;
  assign w_bubble     = redirect_valid || w_jump_taken;
  assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (reset)
      w_pc_next = RESET_PC;
    else if (redirect_valid)
      w_pc_next = {redirect_pc[31:2], 2'b00};
    else if (stall)
      w_pc_next = r_pc;
    else if (jump && r_id_valid)
      w_pc_next = {r_opcplus4[31:28], Jump_PC, 2'b00};
  end

  // The ROM is addressed with next-PC so its registered output lines up with r_pc.
  assign imem_addr = w_pc_next[IMEM_ADDR_W+1:2];

  always_ff @(posedge clock) begin
    r_pc <= w_pc_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_instr    <= 32'd0;
      r_opcplus4 <= 32'd0;
      r_id_pc    <= 32'd0;
      r_id_valid <= 1'b0;
      r_adderr   <= 1'b0;
    end else begin
      r_adderr <= w_misaligned;
      if (w_bubble) begin
        r_instr    <= 32'd0;
        r_id_valid <= 1'b0;
      end else if (!stall) begin
        r_instr    <= imem_rdata;
        r_id_pc    <= r_pc;
        r_opcplus4 <= w_pc_plus4;
        r_id_valid <= 1'b1;
      end
    end
  end

  assign Instruction = r_instr;
  assign opcplus4    = r_opcplus4;
  assign id_pc       = r_id_pc;
  assign id_valid    = r_id_valid;
  assign adderr      = r_adderr;

endmodule
